// File: rtl/ac_pkg.sv
// Shared types and defaults for the AC plant sequencer: state encoding,
// heat/cool mode, drive bundle and default cycle counts.
package ac_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned DEF_FAN_PRE_CYC  = 4;
  localparam int unsigned DEF_FAN_POST_CYC = 8;
  localparam int unsigned DEF_MIN_ON_CYC   = 16;
  localparam int unsigned DEF_MIN_OFF_CYC  = 32;
  localparam int unsigned DEF_CNT_W        = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HEAT = 3'd2,
    ST_COOL = 3'd3,
    ST_POST = 3'd4,
    ST_REST = 3'd5
  } ac_state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } ac_mode_e;

  typedef struct packed {
    logic fan;
    logic heater;
    logic compressor;
    logic busy;
  } ac_drive_t;

  // Moore decode of plant drives; heater/compressor only ever appear with the fan.
  function automatic ac_drive_t drive_decode(input ac_state_e st);
    ac_drive_t d;
    d            = '0;
    d.fan        = (st == ST_PRE) || (st == ST_HEAT) || (st == ST_COOL) || (st == ST_POST);
    d.heater     = (st == ST_HEAT);
    d.compressor = (st == ST_COOL);
    d.busy       = (st != ST_IDLE);
    return d;
  endfunction

endpackage

// File: rtl/ac_seq_timer.sv
// Loadable down-counter that saturates at zero, with a registered zero flag.
module ac_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/ac_plant_sequencer.sv
// Fan/heater/compressor sequencer behind the thermostat: pre-run, min-on,
// post-run and compressor rest. Optional fault handling via AC_SEQ_FAULT_EN.
module ac_plant_sequencer
  import ac_pkg::*;
#(
  parameter int unsigned FAN_PRE_CYC  = DEF_FAN_PRE_CYC,
  parameter int unsigned FAN_POST_CYC = DEF_FAN_POST_CYC,
  parameter int unsigned MIN_ON_CYC   = DEF_MIN_ON_CYC,
  parameter int unsigned MIN_OFF_CYC  = DEF_MIN_OFF_CYC,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               heat_req,
  input  logic               cool_req,
  input  logic               fault,
  output logic               fan_en,
  output logic               heater_en,
  output logic               compressor_en,
  output logic               busy,
  output logic [STATE_W-1:0] state_o,
  output logic               fault_latched
);

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(FAN_PRE_CYC - 1);
  localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(FAN_POST_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(MIN_OFF_CYC - 1);

  ac_state_e        state_q, state_d;
  ac_mode_e         mode_q, mode_d;
  logic             rest_pend_q, rest_pend_d;
  logic             fault_latched_q, fault_latched_d;
  ac_drive_t        drive_q, drive_d;
  logic             load_c;
  logic [CNT_W-1:0] load_val_c;
  logic             cnt_zero;
  logic             fault_c;

  // Conflicting requests collapse to "no request".
  logic req_heat_c, req_cool_c, req_valid_c, keep_c;
  assign req_heat_c  = heat_req & ~cool_req;
  assign req_cool_c  = cool_req & ~heat_req;
  assign req_valid_c = req_heat_c | req_cool_c;
  assign keep_c      = (mode_q == MODE_HEAT) ? req_heat_c : req_cool_c;

`ifdef AC_SEQ_FAULT_EN
  assign fault_c         = fault;
  assign fault_latched_d = fault_latched_q | fault;
`else
  logic unused_fault_c;
  assign unused_fault_c  = fault;
  assign fault_c         = 1'b0;
  assign fault_latched_d = 1'b0;
`endif

  ac_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .zero_o     (cnt_zero)
  );

  // Next-state, counter load and mode/rest bookkeeping.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rest_pend_d = rest_pend_q;
    load_c      = 1'b0;
    load_val_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_c && !fault_latched_q) begin
          state_d    = ST_PRE;
          load_c     = 1'b1;
          load_val_c = PRE_LOAD;
          mode_d     = req_cool_c ? MODE_COOL : MODE_HEAT;
        end
      end
      ST_PRE: begin
        if (fault_c || !keep_c) begin
          state_d    = ST_POST;
          load_c     = 1'b1;
          load_val_c = POST_LOAD;
        end else if (cnt_zero) begin
          state_d    = (mode_q == MODE_COOL) ? ST_COOL : ST_HEAT;
          load_c     = 1'b1;
          load_val_c = ON_LOAD;
        end
      end
      ST_HEAT: begin
        if (fault_c || (cnt_zero && !keep_c)) begin
          state_d    = ST_POST;
          load_c     = 1'b1;
          load_val_c = POST_LOAD;
        end
      end
      ST_COOL: begin
        if (fault_c || (cnt_zero && !keep_c)) begin
          state_d     = ST_POST;
          load_c      = 1'b1;
          load_val_c  = POST_LOAD;
          rest_pend_d = 1'b1;
        end
      end
      ST_POST: begin
        if (cnt_zero) begin
          if (rest_pend_q) begin
            state_d    = ST_REST;
            load_c     = 1'b1;
            load_val_c = OFF_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_REST: begin
        if (cnt_zero) begin
          state_d     = ST_IDLE;
          rest_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Drives are decoded from the next state so they line up with state_q.
  assign drive_d = drive_decode(state_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mode_q          <= MODE_HEAT;
      rest_pend_q     <= 1'b0;
      fault_latched_q <= 1'b0;
      drive_q         <= '0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      rest_pend_q     <= rest_pend_d;
      fault_latched_q <= fault_latched_d;
      drive_q         <= drive_d;
    end
  end

  assign fan_en        = drive_q.fan;
  assign heater_en     = drive_q.heater;
  assign compressor_en = drive_q.compressor;
  assign busy          = drive_q.busy;
  assign state_o       = state_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_ac_plant_sequencer.sv
// Directed bench for ac_plant_sequencer with hand-derived per-cycle state
// sequences; the fault scenario adapts to AC_SEQ_FAULT_EN.
module tb_ac_plant_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HEAT = 3'd2;
  localparam logic [2:0] S_COOL = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_REST = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, heat_req, cool_req, fault;
  logic       fan_en, heater_en, compressor_en, busy, fault_latched;
  logic [2:0] state_o;
  logic [7:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ac_plant_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .heat_req      (heat_req),
    .cool_req      (cool_req),
    .fault         (fault),
    .fan_en        (fan_en),
    .heater_en     (heater_en),
    .compressor_en (compressor_en),
    .busy          (busy),
    .state_o       (state_o),
    .fault_latched (fault_latched)
  );

  assign obs = {fault_latched, fan_en, heater_en, compressor_en, busy, state_o};

  // Expected observation vector for a given state and fault flag.
  function automatic logic [7:0] exp_vec(input logic [2:0] st, input logic fl);
    logic fan, htr, cmp, bsy;
    fan = (st == S_PRE) || (st == S_HEAT) || (st == S_COOL) || (st == S_POST);
    htr = (st == S_HEAT);
    cmp = (st == S_COOL);
    bsy = (st != S_IDLE);
    return {fl, fan, htr, cmp, bsy, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] ev;
    rst_n = 1'b0; heat_req = 1'b0; cool_req = 1'b0; fault = 1'b0;
    tick(); tick();
    ev = 8'h00;
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL reset got=%b exp=%b", obs, ev);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL reset_release got=%b exp=%b", obs, ev);
    end
  endtask

  task automatic test_heat_run();
    logic [2:0] st;
    logic [7:0] ev;
    heat_req = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      tick();
      st = (k < 5) ? S_PRE : (k <= 40) ? S_HEAT : (k <= 48) ? S_POST : S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL heat_run k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 40) heat_req = 1'b0;
    end
  endtask

  task automatic test_cool_pulse();
    logic [2:0] st;
    logic [7:0] ev;
    cool_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      st = (k <= 3) ? S_PRE : (k <= 11) ? S_POST : S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL cool_pulse k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 3) cool_req = 1'b0;
    end
  endtask

  task automatic test_cool_rest();
    logic [2:0] st;
    logic [7:0] ev;
    cool_req = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k <= 4)       st = S_PRE;
      else if (k <= 20) st = S_COOL;
      else if (k <= 28) st = S_POST;
      else if (k <= 60) st = S_REST;
      else if (k == 61) st = S_IDLE;
      else if (k == 62) st = S_PRE;
      else if (k <= 70) st = S_POST;
      else              st = S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL cool_rest k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 6)  cool_req = 1'b0;
      if (k == 35) cool_req = 1'b1;
      if (k == 62) cool_req = 1'b0;
    end
  endtask

  task automatic test_conflict();
    logic [7:0] ev;
    heat_req = 1'b1; cool_req = 1'b1;
    ev = exp_vec(S_IDLE, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL conflict k=%0d got=%b exp=%b", k, obs, ev);
      end
    end
    heat_req = 1'b0; cool_req = 1'b0;
    tick();
  endtask

  task automatic test_opposite();
    logic [2:0] st;
    logic [7:0] ev;
    heat_req = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      st = (k < 5) ? S_PRE : (k <= 24) ? S_HEAT : (k <= 32) ? S_POST : S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL opposite k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 24) begin heat_req = 1'b0; cool_req = 1'b1; end
      if (k == 32) cool_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_heat();
    logic [2:0] st;
    logic [7:0] ev;
    heat_req = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    ev = exp_vec(S_HEAT, 1'b0);
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL mid_heat_pre got=%b exp=%b", obs, ev);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL mid_heat_reset got=%b exp=%b", obs, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    ev = exp_vec(S_PRE, 1'b0);
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL mid_heat_restart got=%b exp=%b", obs, ev);
    end
    heat_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      st = (k <= 8) ? S_POST : S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL mid_heat_drain k=%0d got=%b exp=%b", k, obs, ev);
      end
    end
  endtask

  task automatic test_fault();
    logic [2:0] st;
    logic [7:0] ev;
    cool_req = 1'b1;
`ifdef AC_SEQ_FAULT_EN
    for (int k = 1; k <= 55; k++) begin
      tick();
      if (k <= 4)       st = S_PRE;
      else if (k <= 8)  st = S_COOL;
      else if (k <= 16) st = S_POST;
      else if (k <= 48) st = S_REST;
      else              st = S_IDLE;
      ev = exp_vec(st, (k >= 9));
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL fault_cool k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 8)  fault = 1'b1;
      if (k == 9)  fault = 1'b0;
      if (k == 52) begin cool_req = 1'b0; heat_req = 1'b1; end
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL fault_reset got=%b exp=%b", obs, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    ev = exp_vec(S_PRE, 1'b0);
    n_cmp++;
    if (obs !== ev) begin
      n_err++; $display("FAIL fault_recover got=%b exp=%b", obs, ev);
    end
    heat_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      st = (k <= 8) ? S_POST : S_IDLE;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL fault_drain k=%0d got=%b exp=%b", k, obs, ev);
      end
    end
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      st = (k <= 4) ? S_PRE : S_COOL;
      ev = exp_vec(st, 1'b0);
      n_cmp++;
      if (obs !== ev) begin
        n_err++; $display("FAIL fault_ignored k=%0d got=%b exp=%b", k, obs, ev);
      end
      if (k == 8) fault = 1'b1;
      if (k == 9) fault = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL fault_reset got=%b exp=%b", obs, 8'h00);
    end
    cool_req = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++; $display("FAIL fault_idle got=%b exp=%b", obs, 8'h00);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_heat_run();
    test_cool_pulse();
    test_cool_rest();
    test_conflict();
    test_opposite();
    test_reset_mid_heat();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ac_plant_sequencer.md
# ac_plant_sequencer

Sequences the heating/cooling plant behind the thermostat controller. Takes the thermostat's `heat_req`/`cool_req` demands and drives the fan, heater and compressor enables. It enforces:
- fan pre-run before heat or cool;
- fan post-run after heat or cool;
- a minimum on-time for heater and compressor;
- a compressor minimum off-time (anti-short-cycle).

It sits between the thermostat decision logic and the plant output pins.

## Interface
Parameters:
- `FAN_PRE_CYC`, 4: fan-only cycles before heater/compressor enable. Legal range ≥1.
- `FAN_POST_CYC`, 8: fan-only cycles after heater/compressor disable. Legal range ≥1.
- `MIN_ON_CYC`, 16: minimum heater/compressor on cycles. Legal range ≥1.
- `MIN_OFF_CYC`, 32: compressor rest cycles after a cool run. Legal range ≥1.
- `CNT_W`, 8: counter width. Every cycle parameter minus 1 must fit in `CNT_W` bits.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `heat_req` input 1: heating demand from thermostat (level).
- `cool_req` input 1: cooling demand from thermostat (level).
- `fault` input 1: plant fault. Only acts when `AC_SEQ_FAULT_EN` is defined.
- `fan_en` output 1: fan drive.
- `heater_en` output 1: heater drive.
- `compressor_en` output 1: compressor drive.
- `busy` output 1: high whenever state ≠ IDLE.
- `state_o` output 3: current state encoding (debug).
- `fault_latched` output 1: sticky fault flag.

## Operation
- States: IDLE, PRE, HEAT, COOL, POST, REST.
- One down-counter `cnt`. It is loaded with N−1 on state entry, decrements each cycle and saturates at 0.
- Valid request: exactly one of `heat_req`/`cool_req` high. Both high = conflict, treated as "no request".
- Register `mode` (heat/cool) is latched on IDLE→PRE. Flag `rest_pend` is set on COOL exit and cleared on REST exit.

State behaviour:
- **IDLE:** all drives off.
  - Valid request → PRE; load `FAN_PRE_CYC`−1; latch `mode`.
- **PRE:** `fan_en`=1.
  - Latched request withdrawn or conflict → POST; load `FAN_POST_CYC`−1. No heater/compressor pulse.
  - Otherwise, at `cnt`==0 → HEAT or COOL per `mode`; load `MIN_ON_CYC`−1.
- **HEAT:** `fan_en`=`heater_en`=1.
  - Exit → POST only when `cnt`==0 and (`heat_req`==0 or conflict).
  - Opposite request alone also counts as withdrawal.
- **COOL:** `fan_en`=`compressor_en`=1.
  - Exit symmetric to HEAT → POST; set `rest_pend`.
- **POST:** `fan_en`=1. Requests are ignored.
  - At `cnt`==0 → REST (load `MIN_OFF_CYC`−1) if `rest_pend`, else → IDLE.
- **REST:** all drives off, `busy`=1. Requests are ignored.
  - At `cnt`==0 → IDLE.

Output and reset rules:
- `heater_en` and `compressor_en` are never high together. Neither is high without `fan_en`.
- Outputs are registered Moore decodes of the state register.
- Reset (`rst_n`=0 at an edge) forces IDLE, `cnt`=0, `mode`=heat, `rest_pend`=0, `fault_latched`=0 and all outputs 0 after that edge.
- Reset overrides min-on and post-run when asserted mid-operation.

## Timing
- Request sampled high at edge N: `fan_en` rises after edge N.
- Heater/compressor rises after edge N+`FAN_PRE_CYC`.
- Heater/compressor stays high for ≥`MIN_ON_CYC` cycles.
- Request drop while `cnt`==0 in HEAT/COOL: the drive falls after the next edge, and `fan_en` stays high for `FAN_POST_CYC` more cycles.
- REST holds everything off for exactly `MIN_OFF_CYC` cycles. The earliest re-entry to PRE is at the edge after REST→IDLE, because IDLE samples requests.
- Request glitches shorter than one cycle are not filtered. The thermostat supplies clean levels.

## Configuration
- `AC_SEQ_FAULT_EN` defined:
  - `fault` high at an edge in PRE/HEAT/COOL → POST next edge (drives off, fan purges); `rest_pend` set if leaving COOL.
  - The same edge sets `fault_latched`. It stays set until reset.
  - While `fault_latched`=1, IDLE ignores requests.
  - `fault` in POST/REST/IDLE only sets `fault_latched`.
- `AC_SEQ_FAULT_EN` undefined: `fault` ignored; `fault_latched` tied 0.

## Structure
- Package `ac_pkg` holds:
  - state enum/encoding (IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4, REST=5);
  - mode constants;
  - default cycle constants.
- Sub-module `ac_seq_timer`: loadable down-counter, saturating at 0, `zero` flag output, width `CNT_W`.
- Top holds the FSM, `mode`/`rest_pend` registers and output decode.

## Test plan
- Defaults, `heat_req`=1 held 40 cycles then 0 → `fan_en` rises after edge 1; `heater_en` high from cycle 5 until 1 cycle after drop; `fan_en` high 8 more cycles; IDLE, no REST.
- `cool_req` pulse 3 cycles → PRE then POST; `compressor_en` never asserted; no REST; IDLE after 8 fan cycles.
- `cool_req` for 6 cycles → PRE then COOL; `compressor_en` high exactly 16 cycles; POST 8; REST 32 with `busy`=1; a `cool_req` during REST is ignored until IDLE.
- `heat_req` and `cool_req` both high from IDLE for 10 cycles → stays IDLE, all outputs 0.
- In HEAT, `rst_n`=0 one edge → all outputs 0 and `state_o`=0 next cycle.
- With `AC_SEQ_FAULT_EN`: `fault` pulse in COOL → compressor off next edge, POST, REST, `fault_latched`=1; later `heat_req` → no response until reset.
